// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the byte-serial memory controller: FSM states, size codes, stall vectors.
// Latency: none (types, constants and pure helper functions only).
// Backpressure: not applicable.
package mem_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        IF_RD  = 3'd1,
        MEM_RD = 3'd2,
        MEM_WR = 3'd3,
        DONE   = 3'd4
    } state_t;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    localparam int STALL_W = 6;
    // bit 0 = PC, 1 = IF, 2 = ID, 3 = EX, 4 = MEM, 5 = WB
    localparam logic [STALL_W-1:0] STALL_MEM  = 6'b011111;
    localparam logic [STALL_W-1:0] STALL_IF   = 6'b000011;
    localparam logic [STALL_W-1:0] STALL_NONE = 6'b000000;

    // Number of RAM byte beats for a given size code; code 3 behaves as a word.
    function automatic logic [2:0] xfer_len(input logic [1:0] size);
        case (size)
            SIZE_BYTE: xfer_len = 3'd1;
            SIZE_HALF: xfer_len = 3'd2;
            default:   xfer_len = 3'd4;
        endcase
    endfunction

    // Sign- or zero-extend the low bytes of an assembled little-endian word.
    function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [1:0] size,
                                             input logic sgn);
        case (size)
            SIZE_BYTE: load_ext = {{24{sgn & w[7]}}, w[7:0]};
            SIZE_HALF: load_ext = {{16{sgn & w[15]}}, w[15:0]};
            default:   load_ext = w;
        endcase
    endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// Bundle of fetch, data-access, RAM and stall signals between the pipeline/RAM and mem_ctrl.
// Latency: none (wiring only).
// Backpressure: requests are levels held by the requester until the matching done pulse.
interface mem_ctrl_if;
    import mem_ctrl_pkg::*;

    logic                if_req;
    logic [31:0]         if_addr;
    logic                if_done;
    logic [31:0]         if_data;

    logic                mem_req;
    logic                mem_we;
    logic [1:0]          mem_size;
    logic                mem_signed;
    logic [31:0]         mem_addr;
    logic [31:0]         mem_wdata;
    logic                mem_done;
    logic [31:0]         mem_rdata;

    logic [31:0]         ram_addr;
    logic                ram_wr;
    logic [7:0]          ram_dout;
    logic [7:0]          ram_din;

    logic [STALL_W-1:0]  stall;

    // Controller side
    modport slave (
        input  if_req, if_addr, mem_req, mem_we, mem_size, mem_signed, mem_addr, mem_wdata,
               ram_din,
        output if_done, if_data, mem_done, mem_rdata, ram_addr, ram_wr, ram_dout, stall
    );

    // Pipeline and RAM side
    modport master (
        output if_req, if_addr, mem_req, mem_we, mem_size, mem_signed, mem_addr, mem_wdata,
               ram_din,
        input  if_done, if_data, mem_done, mem_rdata, ram_addr, ram_wr, ram_dout, stall
    );

endinterface

// File: rtl/mem_ctrl.sv
// Arbitrates instruction fetch and data load/store onto a byte-wide RAM, data access first.
// Latency: read N+2 cycles, write N+1 cycles from the IDLE sample (N = 1/2/4 bytes, fetch 4).
// Backpressure: requesters hold their level request; stall freezes the pipeline until done.
module mem_ctrl
    import mem_ctrl_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    mem_ctrl_if.slave bus
);

    state_t      state_q;
    state_t      state_d;
    logic [2:0]  cnt_q;
    logic        owner_mem_q;
    logic [31:0] base_q;
    logic [31:0] wdata_q;
    logic [31:0] buf_q;
    logic [1:0]  size_q;
    logic        signed_q;
    logic [31:0] if_data_q;
    logic [31:0] mem_rdata_q;
    logic [31:0] word_nxt;
    logic [2:0]  len;
    logic        mem_pend;
    logic        if_pend;

    assign len = xfer_len(size_q);

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state: data access beats fetch; reads need one extra beat for the last capture
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.mem_req)     state_d = bus.mem_we ? MEM_WR : MEM_RD;
                else if (bus.if_req) state_d = IF_RD;
            end
            IF_RD, MEM_RD: if (cnt_q == len) state_d = DONE;
            MEM_WR:        if (cnt_q == len - 3'd1) state_d = DONE;
            DONE:          state_d = IDLE;
            default:       state_d = IDLE;
        endcase
    end

    // Merge the byte returned for the previous beat into its lane
    always_comb begin
        word_nxt = buf_q;
        case (cnt_q)
            3'd1:    word_nxt[7:0]   = bus.ram_din;
            3'd2:    word_nxt[15:8]  = bus.ram_din;
            3'd3:    word_nxt[23:16] = bus.ram_din;
            3'd4:    word_nxt[31:24] = bus.ram_din;
            default: ;
        endcase
    end

    // Request latch, beat counter, read assembly and held result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= '0;
            owner_mem_q <= 1'b0;
            base_q      <= '0;
            wdata_q     <= '0;
            buf_q       <= '0;
            size_q      <= SIZE_BYTE;
            signed_q    <= 1'b0;
            if_data_q   <= '0;
            mem_rdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    buf_q <= '0;
                    if (bus.mem_req) begin
                        owner_mem_q <= 1'b1;
                        base_q      <= bus.mem_addr;
                        wdata_q     <= bus.mem_wdata;
                        size_q      <= bus.mem_size;
                        signed_q    <= bus.mem_signed;
                    end else if (bus.if_req) begin
                        owner_mem_q <= 1'b0;
                        base_q      <= bus.if_addr;
                        size_q      <= SIZE_WORD;
                        signed_q    <= 1'b0;
                    end
                end
                IF_RD, MEM_RD: begin
                    cnt_q <= cnt_q + 3'd1;
                    buf_q <= word_nxt;
                    if (cnt_q == len) begin
                        if (owner_mem_q) mem_rdata_q <= load_ext(word_nxt, size_q, signed_q);
                        else             if_data_q   <= word_nxt;
                    end
                end
                MEM_WR:  cnt_q <= cnt_q + 3'd1;
                default: cnt_q <= '0;
            endcase
        end
    end

    // RAM drive, done pulses and stall vector decoded from state and owner
    always_comb begin
        bus.ram_addr = '0;
        bus.ram_wr   = 1'b0;
        bus.ram_dout = '0;
        bus.if_done  = 1'b0;
        bus.mem_done = 1'b0;
        mem_pend     = 1'b0;
        if_pend      = 1'b0;
        case (state_q)
            IDLE: begin
                mem_pend = bus.mem_req;
                if_pend  = bus.if_req;
            end
            IF_RD, MEM_RD: begin
                bus.ram_addr = base_q + {29'd0, cnt_q};
                mem_pend     = owner_mem_q;
                if_pend      = !owner_mem_q;
            end
            MEM_WR: begin
                bus.ram_addr = base_q + {29'd0, cnt_q};
                bus.ram_wr   = 1'b1;
                bus.ram_dout = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
                mem_pend     = owner_mem_q;
            end
            DONE: begin
                bus.if_done  = !owner_mem_q;
                bus.mem_done = owner_mem_q;
                mem_pend     = !owner_mem_q && bus.mem_req;
                if_pend      = owner_mem_q && bus.if_req;
            end
            default: ;
        endcase
        bus.stall = mem_pend ? STALL_MEM : (if_pend ? STALL_IF : STALL_NONE);
    end

    assign bus.if_data   = if_data_q;
    assign bus.mem_rdata = mem_rdata_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl: directed cases plus randomized fetch/load/store traffic.
// Expected results come from a byte-array memory model and plain arithmetic on sizes.
// A monitor pops the scoreboard on every done pulse and checks every RAM write beat.
module tb_mem_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_ctrl_if bus();
    mem_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

    localparam logic [5:0] ST_MEM  = 6'b011111;
    localparam logic [5:0] ST_IF   = 6'b000011;
    localparam logic [5:0] ST_NONE = 6'b000000;

    typedef struct {
        bit          is_mem;
        bit          has_data;
        logic [31:0] data;
        int          due;
    } exp_t;

    typedef struct {
        logic [31:0] a;
        logic [7:0]  d;
    } wr_t;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    logic rst_q = 1'b1;

    logic [7:0] ram [logic [31:0]];
    logic [7:0] model_mem [logic [31:0]];
    exp_t exp_q[$];
    wr_t  wr_q[$];

    logic [31:0] last_if = '0;
    logic [31:0] last_rd = '0;
    bit          rd_known = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] ram_rd(input logic [31:0] a);
        return ram.exists(a) ? ram[a] : 8'h00;
    endfunction

    function automatic logic [7:0] model_rd(input logic [31:0] a);
        return model_mem.exists(a) ? model_mem[a] : 8'h00;
    endfunction

    task automatic poke(input logic [31:0] a, input logic [7:0] d);
        ram[a] = d;
        model_mem[a] = d;
    endtask

    // Little-endian assembly of n bytes with 32-bit address wrap, then extension.
    function automatic logic [31:0] model_load(input logic [31:0] addr, input int n, input bit sgn);
        logic [31:0] v;
        v = '0;
        for (int i = 0; i < n; i++)
            v = v | (32'(model_rd(addr + 32'(i))) << (8 * i));
        if (sgn && n < 4 && v[8 * n - 1])
            v = v | ~((32'd1 << (8 * n)) - 32'd1);
        return v;
    endfunction

    // RAM: read data one cycle after the address, writes on the strobe
    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= rst;
        bus.ram_din <= ram_rd(bus.ram_addr);
        if (bus.ram_wr) ram[bus.ram_addr] = bus.ram_dout;
    end

    // Monitor: done pulses against scoreboard, held outputs, and every write beat
    always @(negedge clk) begin
        exp_t e;
        wr_t  w;
        if (bus.if_done || bus.mem_done) begin
            check("done_overlap", {31'b0, bus.if_done & bus.mem_done}, 32'd0);
            check("done_expected", {31'b0, exp_q.size() != 0}, 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("done_owner", {31'b0, bus.mem_done}, {31'b0, e.is_mem});
                check("done_cycle", cyc, e.due);
                if (e.is_mem) begin
                    if (e.has_data) begin
                        check("mem_rdata", bus.mem_rdata, e.data);
                        last_rd  = e.data;
                        rd_known = 1'b1;
                    end else begin
                        rd_known = 1'b0;
                    end
                end else begin
                    check("if_data", bus.if_data, e.data);
                    last_if = e.data;
                end
            end
        end else if (rst_q) begin
            last_if  = '0;
            last_rd  = '0;
            rd_known = 1'b1;
        end else begin
            check("if_data_hold", bus.if_data, last_if);
            if (rd_known) check("mem_rdata_hold", bus.mem_rdata, last_rd);
        end
        if (bus.ram_wr) begin
            check("write_expected", {31'b0, wr_q.size() != 0}, 32'd1);
            if (wr_q.size() != 0) begin
                w = wr_q.pop_front();
                check("ram_wr_addr", bus.ram_addr, w.a);
                check("ram_dout", {24'b0, bus.ram_dout}, {24'b0, w.d});
            end
        end
    end

    task automatic drop_req(input bit is_mem);
        if (is_mem) bus.mem_req = 1'b0;
        else        bus.if_req  = 1'b0;
    endtask

    // Wait for this requester's done pulse, checking stall each cycle on the way
    task automatic wait_done(input bit is_mem, input logic [5:0] busy_stall,
                             input logic [5:0] done_stall, input int drop_at);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 24 && !got; i++) begin
            @(negedge clk);
            if (is_mem ? bus.mem_done : bus.if_done) begin
                got = 1'b1;
                check("stall_at_done", {26'b0, bus.stall}, {26'b0, done_stall});
                drop_req(is_mem);
            end else begin
                check("stall_busy", {26'b0, bus.stall}, {26'b0, busy_stall});
                if (i == drop_at) drop_req(is_mem);
            end
        end
        if (!got) begin
            check("done_timeout", {31'b0, got}, 32'd1);
            drop_req(is_mem);
        end
    endtask

    // kind: 0 = fetch, 1 = load, 2 = store
    task automatic run_op(input int kind, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [1:0] size, input bit sgn, input bit drop_en);
        int   n;
        int   lat;
        int   drop_at;
        exp_t e;
        wr_t  w;
        @(negedge clk);
        n = (kind == 0 || size >= 2'd2) ? 4 : ((size == 2'd1) ? 2 : 1);
        e.is_mem   = (kind != 0);
        e.has_data = (kind != 2);
        if (kind == 2) begin
            e.data = '0;
            for (int i = 0; i < n; i++) begin
                w.a = addr + 32'(i);
                w.d = 8'(wdata >> (8 * i));
                wr_q.push_back(w);
                model_mem[w.a] = w.d;
            end
            lat = n + 1;
        end else begin
            e.data = model_load(addr, n, (kind == 1) && sgn);
            lat = n + 2;
        end
        e.due = cyc + lat;
        exp_q.push_back(e);
        drop_at = drop_en ? int'($urandom_range(0, lat - 2)) : -1;
        if (kind == 0) begin
            bus.if_addr = addr;
            bus.if_req  = 1'b1;
        end else begin
            bus.mem_addr   = addr;
            bus.mem_we     = (kind == 2);
            bus.mem_size   = size;
            bus.mem_signed = sgn;
            bus.mem_wdata  = wdata;
            bus.mem_req    = 1'b1;
        end
        #1;
        check("stall_issue", {26'b0, bus.stall}, {26'b0, (kind == 0) ? ST_IF : ST_MEM});
        wait_done(kind != 0, (kind == 0) ? ST_IF : ST_MEM, ST_NONE, drop_at);
        bus.mem_we = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

    initial begin
        exp_t        e;
        int          kind;
        logic [31:0] a;
        bus.if_req     = 1'b0;
        bus.if_addr    = '0;
        bus.mem_req    = 1'b0;
        bus.mem_we     = 1'b0;
        bus.mem_size   = 2'd0;
        bus.mem_signed = 1'b0;
        bus.mem_addr   = '0;
        bus.mem_wdata  = '0;

        poke(32'h100, 8'h11); poke(32'h101, 8'h22); poke(32'h102, 8'h33); poke(32'h103, 8'h44);
        poke(32'h200, 8'h80);
        poke(32'h400, 8'hAA); poke(32'h401, 8'hBB); poke(32'h402, 8'hCC); poke(32'h403, 8'hDD);
        poke(32'hFFFF_FFFF, 8'h34); poke(32'h0, 8'h12);
        for (int i = 0; i < 64; i++) poke(32'h1000 + 32'(i), 8'($urandom));
        for (int i = 1; i < 8; i++) poke(32'h0 + 32'(i), 8'($urandom));
        for (int i = 0; i < 7; i++) poke(32'hFFFF_FFF8 + 32'(i), 8'($urandom));

        // Reset state
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_if_done",   {31'b0, bus.if_done}, 32'd0);
        check("rst_mem_done",  {31'b0, bus.mem_done}, 32'd0);
        check("rst_if_data",   bus.if_data, 32'd0);
        check("rst_mem_rdata", bus.mem_rdata, 32'd0);
        check("rst_ram_wr",    {31'b0, bus.ram_wr}, 32'd0);
        check("rst_ram_addr",  bus.ram_addr, 32'd0);
        check("rst_ram_dout",  {24'b0, bus.ram_dout}, 32'd0);
        check("rst_stall",     {26'b0, bus.stall}, {26'b0, ST_NONE});
        bus.mem_req = 1'b1;
        #1 check("rst_stall_memreq", {26'b0, bus.stall}, {26'b0, ST_MEM});
        bus.mem_req = 1'b0;
        bus.if_req  = 1'b1;
        #1 check("rst_stall_ifreq", {26'b0, bus.stall}, {26'b0, ST_IF});
        bus.if_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // Fetch, signed/unsigned byte loads, word store
        run_op(0, 32'h100, 32'h0, 2'd2, 1'b0, 1'b0);
        run_op(1, 32'h200, 32'h0, 2'd0, 1'b1, 1'b0);
        run_op(1, 32'h200, 32'h0, 2'd0, 1'b0, 1'b0);
        run_op(2, 32'h300, 32'hDEAD_BEEF, 2'd2, 1'b0, 1'b0);
        run_op(1, 32'h300, 32'h0, 2'd2, 1'b0, 1'b0);

        // Simultaneous requests: data access first, fetch right after
        @(negedge clk);
        e.is_mem = 1'b1; e.has_data = 1'b1;
        e.data = model_load(32'h200, 4, 1'b0); e.due = cyc + 6;
        exp_q.push_back(e);
        e.is_mem = 1'b0; e.has_data = 1'b1;
        e.data = model_load(32'h100, 4, 1'b0); e.due = cyc + 13;
        exp_q.push_back(e);
        bus.mem_addr = 32'h200; bus.mem_we = 1'b0; bus.mem_size = 2'd2; bus.mem_signed = 1'b0;
        bus.if_addr  = 32'h100;
        bus.mem_req  = 1'b1;
        bus.if_req   = 1'b1;
        #1 check("stall_both_issue", {26'b0, bus.stall}, {26'b0, ST_MEM});
        wait_done(1'b1, ST_MEM, ST_IF, -1);
        wait_done(1'b0, ST_IF, ST_NONE, -1);

        // Reset during the second beat of a word store
        @(negedge clk);
        bus.mem_addr = 32'h400; bus.mem_we = 1'b1; bus.mem_size = 2'd2;
        bus.mem_wdata = 32'h1122_3344; bus.mem_req = 1'b1;
        wr_q.push_back('{a: 32'h400, d: 8'h44});
        wr_q.push_back('{a: 32'h401, d: 8'h33});
        model_mem[32'h400] = 8'h44;
        model_mem[32'h401] = 8'h33;
        @(negedge clk);
        @(negedge clk);
        check("abort_wr_beat2", {31'b0, bus.ram_wr}, 32'd1);
        rst = 1'b1;
        bus.mem_req = 1'b0;
        bus.mem_we  = 1'b0;
        @(negedge clk);
        check("abort_ram_wr",   {31'b0, bus.ram_wr}, 32'd0);
        check("abort_mem_done", {31'b0, bus.mem_done}, 32'd0);
        check("abort_ram_addr", bus.ram_addr, 32'd0);
        check("abort_stall",    {26'b0, bus.stall}, {26'b0, ST_NONE});
        rst = 1'b0;
        run_op(1, 32'h400, 32'h0, 2'd2, 1'b0, 1'b0);

        // Half load straddling the top of the address space
        run_op(1, 32'hFFFF_FFFF, 32'h0, 2'd1, 1'b0, 1'b0);
        run_op(1, 32'hFFFF_FFFF, 32'h0, 2'd1, 1'b1, 1'b0);

        // Randomized traffic, including dropped requests and size code 3
        for (int k = 0; k < 60; k++) begin
            kind = int'($urandom_range(0, 2));
            if ($urandom_range(0, 5) == 0) a = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
            else                           a = 32'h1000 + 32'($urandom_range(0, 60));
            run_op(kind, a, $urandom, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   $urandom_range(0, 3) == 0);
        end

        repeat (3) @(negedge clk);
        check("pending_done",   32'(exp_q.size()), 32'd0);
        check("pending_writes", 32'(wr_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 clk  in  1  system clock; all state changes on rising edge.
REQ-002 rst  in  1  reset; synchronous, active-high.
REQ-003 if_req  in  1  instruction fetch request; level, held until if_done.
REQ-004 if_addr  in  32  fetch byte address.
REQ-005 if_done  out  1  one-cycle pulse: if_data valid.
REQ-006 if_data  out  32  fetched word, little-endian.
REQ-007 mem_req  in  1  data access request; level, held until mem_done.
REQ-008 mem_we  in  1  1 = store, 0 = load.
REQ-009 mem_size  in  2  0 = byte, 1 = half, 2 = word; 3 is treated as word.
REQ-010 mem_signed  in  1  load sign-extends when 1, zero-extends when 0.
REQ-011 mem_addr / mem_wdata  in  32 / 32  data address and store data; store bytes are taken from the low bytes.
REQ-012 mem_done  out  1  one-cycle pulse: load data valid or store complete.
REQ-013 mem_rdata  out  32  extended load result.
REQ-014 ram_addr  out  32  RAM byte address.
REQ-015 ram_wr  out  1  RAM write strobe.
REQ-016 ram_dout  out  8  RAM write byte.
REQ-017 ram_din  in  8  RAM read byte; valid one cycle after ram_addr is presented.
REQ-018 stall  out  6  pipeline stall vector; bit 0 = PC, 1 = IF, 2 = ID, 3 = EX, 4 = MEM, 5 = WB.

Function
REQ-019 FSM states SHALL be IDLE, IF_RD, MEM_RD, MEM_WR, DONE; a byte counter cnt (0..4) and an owner flag SHALL accompany them.
REQ-020 In IDLE, mem_req SHALL win over if_req when both are high.
- Transitions: mem_req & mem_we -> MEM_WR; mem_req & !mem_we -> MEM_RD; otherwise if_req -> IF_RD.
REQ-021 Transfer length N SHALL be 4 for fetch and 1/2/4 for mem_size 0/1/2.
- Base address and size SHALL be latched on leaving IDLE.
REQ-022 Read: in cycles c = 0..N-1, drive ram_addr = base+c and ram_wr = 0.
- Capture ram_din into byte lane c at cycle c+1.
- Enter DONE after the last capture; read latency from the IDLE sample SHALL be N+2 cycles.
REQ-023 Write: in cycles c = 0..N-1, drive ram_wr = 1, ram_addr = base+c, ram_dout = byte c of the latched wdata; then enter DONE.
REQ-024 Address increment SHALL wrap modulo 2^32; misaligned accesses SHALL be legal.
REQ-025 DONE SHALL last exactly one cycle.
- Pulse if_done or mem_done according to owner.
- No new request is sampled in DONE; next state is IDLE.
REQ-026 if_data / mem_rdata SHALL hold their value until the next completion.
- mem_rdata SHALL be extended per mem_signed and the size latched at start.
REQ-027 stall SHALL be combinational:
- 6'b011111 while a mem access is pending (mem_req high in IDLE, or owner = mem, excluding DONE).
- else 6'b000011 while a fetch is pending.
- else 6'b000000.
- In the DONE cycle, stall SHALL be 0 for the completing owner unless the other requester is pending.
REQ-028 ram_wr SHALL be 0 in IDLE, DONE, IF_RD, and MEM_RD.
REQ-029 A request dropped mid-transfer SHALL not abort the transfer; the done pulse is still issued.

Reset
REQ-030 rst SHALL force state IDLE, cnt 0, ram_wr 0, ram_addr 0, ram_dout 0, if_done 0, mem_done 0, if_data 0, mem_rdata 0; stall then follows REQ-027 combinationally from the requests.
REQ-031 rst mid-transfer SHALL abort with no done pulse; bytes already written remain in RAM.

Structure
REQ-032 Stall vector constants, mem_size encodings, and FSM state encodings SHALL live in the shared Defines include.
REQ-033 The block SHALL be a single module; no sub-module is warranted.

Verification
REQ-034 Fetch if_addr = 0x100, RAM[0x100..0x103] = 11 22 33 44.
- if_done 6 cycles after the request is sampled; if_data = 0x44332211.
- stall = 000011 until the done cycle.
REQ-035 Load byte, signed, at 0x200, RAM = 0x80.
- mem_rdata = 0xFFFFFF80.
- Same access unsigned -> 0x00000080.
REQ-036 Store word 0xDEADBEEF at 0x300.
- ram_wr high for 4 cycles with bytes EF BE AD DE at 0x300..0x303.
- mem_done in the following cycle.
REQ-037 if_req and mem_req raised in the same cycle.
- Mem access is served first with stall = 011111; fetch follows after DONE.
REQ-038 rst asserted during the 2nd byte of a word store.
- No mem_done; ram_wr = 0 the next cycle; state is IDLE.
REQ-039 Half load at 0xFFFFFFFF.
- Second byte read from 0x00000000 (wrap-around).
